cpu_bus_sequencer: RTL and testbench

CPU_BUS_SEQUENCER -- requirements
Module: cpu_bus_sequencer

---
 rtl/centipede_pkg.sv | 27 ++
 rtl/cpu_bus_sequencer_wdog_timer.sv | 56 +++++
 rtl/cpu_bus_sequencer.sv | 140 ++++++++++++++
 tb/tb_cpu_bus_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/centipede_pkg.sv
// Shared types and defaults for the CPU bus sequencer and its watchdog.
package centipede_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ACCESS,
    ST_CAPTURE
  } bus_state_t;

  localparam int unsigned DEF_DIV         = 68;
  localparam int unsigned DEF_SETUP       = 8;
  localparam int unsigned DEF_WDOG_FRAMES = 8;
  localparam int unsigned DEF_RST_CYCLES  = 16;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

  function automatic int unsigned count_low(input logic [4:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (!v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/cpu_bus_sequencer_wdog_timer.sv
// Watchdog: counts vblank rising edges and issues a fixed-width CPU reset
// pulse when the frame count saturates without a watchdog write.
module wdog_timer
  import centipede_pkg::*;
#(
  parameter int unsigned WDOG_FRAMES = DEF_WDOG_FRAMES,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic vblank,
  input  logic wdog_clr,
  output logic cpu_rst
);

  localparam int unsigned FW = $clog2(WDOG_FRAMES + 1);
  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic          vblank_q;
  logic [FW-1:0] frames_q;
  logic [RW-1:0] rst_cnt_q;
  logic          vblank_rise;
  logic          pulse_done;

  assign vblank_rise = vblank & ~vblank_q;
  assign pulse_done  = cpu_rst && (rst_cnt_q == RW'(RST_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q  <= 1'b0;
      frames_q  <= '0;
      rst_cnt_q <= '0;
      cpu_rst   <= 1'b0;
    end else begin
      vblank_q <= vblank;

      if (cpu_rst) begin
        if (pulse_done) cpu_rst <= 1'b0;
        rst_cnt_q <= rst_cnt_q + RW'(1);
      end else if (frames_q == FW'(WDOG_FRAMES)) begin
        cpu_rst   <= 1'b1;
        rst_cnt_q <= '0;
      end

      // A watchdog write beats a same-cycle vblank edge; the end of the
      // reset pulse clears the saturated count last.
      if (wdog_clr) begin
        frames_q <= '0;
      end else if (vblank_rise && (frames_q != FW'(WDOG_FRAMES))) begin
        frames_q <= frames_q + FW'(1);
      end
      if (pulse_done) frames_q <= '0;
    end
  end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// CPU bus cycle sequencer: clock-enable divider, four-phase bus FSM,
// read-data latch, write strobe, IRQ latch and watchdog reset.
module cpu_bus_sequencer
  import centipede_pkg::*;
#(
  parameter int unsigned DIV         = DEF_DIV,
  parameter int unsigned SETUP       = DEF_SETUP,
  parameter int unsigned WDOG_FRAMES = DEF_WDOG_FRAMES,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_we_l,
  input  logic [7:0] cpu_dout,
  input  logic       ram_l,
  input  logic       rom_l,
  input  logic       gfx_l,
  input  logic       pokey_l,
  input  logic       in_l,
  input  logic       watchdog_l,
  input  logic       irqres_l,
  input  logic [7:0] ram_d,
  input  logic [7:0] rom_d,
  input  logic [7:0] gfx_d,
  input  logic [7:0] pokey_d,
  input  logic [7:0] in_d,
  input  logic       vblank,
  input  logic       irq_tick,
  output logic       cpu_ce,
  output logic [7:0] cpu_din,
  output logic       wr_stb,
  output logic [7:0] wr_data,
  output logic       irq_l,
  output logic       cpu_rst,
  output logic       bus_conflict
);

  localparam int unsigned DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW       = (SETUP > 2) ? $clog2(SETUP) : 1;
  localparam int unsigned ACC_LAST = (SETUP > 1) ? SETUP - 2 : 0;

  logic [DW-1:0] div_q;
  bus_state_t    state_q, state_d;
  logic [AW-1:0] acc_cnt_q;
  logic          we_q, wdog_q, irqres_q;
  logic [4:0]    sel_q;
  logic [4:0]    sel_l;
  logic [7:0]    rd_data;
  logic          decode_now, capture_now, stb_now, wdog_clr;

  assign sel_l = {ram_l, rom_l, gfx_l, pokey_l, in_l};

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      cpu_ce <= 1'b0;
    end else begin
      cpu_ce <= (div_q == DW'(DIV - 1));
      div_q  <= (div_q == DW'(DIV - 1)) ? '0 : div_q + DW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (cpu_ce) state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_ACCESS;
      ST_ACCESS:  if (acc_cnt_q == AW'(ACC_LAST)) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (cpu_rst) state_d = ST_IDLE;
  end

  // Phase events are taken on the transition edges so their effects are
  // visible during the named phase itself.
  assign decode_now  = (state_q == ST_IDLE)   && (state_d == ST_DECODE);
  assign capture_now = (state_q == ST_ACCESS) && (state_d == ST_CAPTURE);
  assign stb_now     = (state_q == ST_DECODE) && (state_d == ST_ACCESS) &&
                       !we_q && (sel_q != '1);
  assign wdog_clr    = capture_now && !we_q && !wdog_q;

  always_comb begin
    rd_data = OPEN_BUS;
    if      (!sel_q[4]) rd_data = ram_d;
    else if (!sel_q[3]) rd_data = rom_d;
    else if (!sel_q[2]) rd_data = gfx_d;
    else if (!sel_q[1]) rd_data = pokey_d;
    else if (!sel_q[0]) rd_data = in_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      acc_cnt_q    <= '0;
      we_q         <= 1'b1;
      sel_q        <= '1;
      wdog_q       <= 1'b1;
      irqres_q     <= 1'b1;
      wr_data      <= '0;
      wr_stb       <= 1'b0;
      cpu_din      <= OPEN_BUS;
      irq_l        <= 1'b1;
      bus_conflict <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= (state_q == ST_ACCESS) ? acc_cnt_q + AW'(1) : '0;
      wr_stb    <= stb_now;

      if (decode_now) begin
        we_q     <= cpu_we_l;
        sel_q    <= sel_l;
        wdog_q   <= watchdog_l;
        irqres_q <= irqres_l;
        wr_data  <= cpu_dout;
        if (count_low(sel_l) > 1) bus_conflict <= 1'b1;
      end

      if (capture_now && we_q) cpu_din <= rd_data;

      if (irq_tick) begin
        irq_l <= 1'b0;
      end else if (capture_now && !irqres_q) begin
        irq_l <= 1'b1;
      end
    end
  end

  wdog_timer #(
    .WDOG_FRAMES(WDOG_FRAMES),
    .RST_CYCLES (RST_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .vblank  (vblank),
    .wdog_clr(wdog_clr),
    .cpu_rst (cpu_rst)
  );

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Directed plus randomized bench for cpu_bus_sequencer with a timing-level reference model.
module tb_cpu_bus_sequencer;

  localparam int SETUP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_we_l = 1'b0;
  logic [7:0] cpu_dout = '0;
  logic       ram_l = 1'b1, rom_l = 1'b1, gfx_l = 1'b1, pokey_l = 1'b1, in_l = 1'b1;
  logic       watchdog_l = 1'b1, irqres_l = 1'b1;
  logic [7:0] ram_d = 8'h01, rom_d = 8'h02, gfx_d = 8'h03, pokey_d = 8'h04, in_d = 8'h05;
  logic       vblank = 1'b0, irq_tick = 1'b0;
  logic       cpu_ce, wr_stb, irq_l, cpu_rst, bus_conflict;
  logic [7:0] cpu_din, wr_data;

  int   cyc, total, bad;
  logic [7:0] exp_din;
  logic exp_irq, exp_conf;
  logic pend_irqres, pend_read;
  logic [7:0] pend_din;

  cpu_bus_sequencer dut (
    .clk(clk), .reset(reset), .cpu_we_l(cpu_we_l), .cpu_dout(cpu_dout),
    .ram_l(ram_l), .rom_l(rom_l), .gfx_l(gfx_l), .pokey_l(pokey_l), .in_l(in_l),
    .watchdog_l(watchdog_l), .irqres_l(irqres_l),
    .ram_d(ram_d), .rom_d(rom_d), .gfx_d(gfx_d), .pokey_d(pokey_d), .in_d(in_d),
    .vblank(vblank), .irq_tick(irq_tick),
    .cpu_ce(cpu_ce), .cpu_din(cpu_din), .wr_stb(wr_stb), .wr_data(wr_data),
    .irq_l(irq_l), .cpu_rst(cpu_rst), .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at cyc %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at cyc %0d: observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Bit order: {ram, rom, gfx, pokey, in}, active low.
  task automatic drive_sel(input logic [4:0] s);
    {ram_l, rom_l, gfx_l, pokey_l, in_l} = s;
  endtask

  // Quiet bus: a write to nothing, which neither strobes nor touches cpu_din.
  task automatic drive_idle();
    cpu_we_l = 1'b0; drive_sel(5'h1F); watchdog_l = 1'b1; irqres_l = 1'b1;
  endtask

  function automatic logic [7:0] ref_read(input logic [4:0] s);
    if (!s[4]) return ram_d;
    if (!s[3]) return rom_d;
    if (!s[2]) return gfx_d;
    if (!s[1]) return pokey_d;
    if (!s[0]) return in_d;
    return 8'hFF;
  endfunction

  function automatic int n_low(input logic [4:0] s);
    int n = 0;
    for (int b = 0; b < 5; b++) if (!s[b]) n++;
    return n;
  endfunction

  // One clock; 'cap' marks the edge that enters CAPTURE for the current transaction.
  task automatic step(input bit cap, input bit stb_exp);
    logic t;
    t = irq_tick;
    @(posedge clk); #1;
    cyc++;
    irq_tick = 1'b0;
    if (t) exp_irq = 1'b0;
    else if (cap && !pend_irqres) exp_irq = 1'b1;
    if (cap && pend_read) exp_din = pend_din;
    check1("irq_l", irq_l, exp_irq);
    check8("cpu_din", cpu_din, exp_din);
    check1("wr_stb", wr_stb, stb_exp);
  endtask

  task automatic wait_ce();
    for (int i = 0; i < 100 && !cpu_ce; i++) step(1'b0, 1'b0);
    check1("ce_wait", cpu_ce, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    check1("abort_stb", wr_stb, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check1("rst_ce", cpu_ce, 1'b0);
    check1("rst_stb", wr_stb, 1'b0);
    check8("rst_wr_data", wr_data, 8'h00);
    check8("rst_din", cpu_din, 8'hFF);
    check1("rst_irq", irq_l, 1'b1);
    check1("rst_cpu_rst", cpu_rst, 1'b0);
    check1("rst_conflict", bus_conflict, 1'b0);
    reset = 1'b0;
    cyc = 0; exp_din = 8'hFF; exp_irq = 1'b1; exp_conf = 1'b0;
  endtask

  task automatic run_cycle(input logic we, input logic [4:0] s, input logic [7:0] dout,
                           input logic irqres, input logic wdog, input int tick_k);
    bit stb;
    cpu_we_l = we; drive_sel(s); cpu_dout = dout; irqres_l = irqres; watchdog_l = wdog;
    pend_irqres = irqres; pend_read = we; pend_din = ref_read(s);
    stb = (we == 1'b0) && (s != 5'h1F);
    wait_ce();
    for (int k = 1; k <= 12; k++) begin
      if (k == tick_k) irq_tick = 1'b1;
      step(k == SETUP + 1, stb && (k == 2));
      if (k == 1) check8("wr_data", wr_data, dout);
      if (k == 2) begin
        if (n_low(s) > 1) exp_conf = 1'b1;
        check1("bus_conflict", bus_conflict, exp_conf);
      end
    end
    pend_irqres = 1'b1; pend_read = 1'b0;
    drive_idle();
  endtask

  task automatic vblank_edges(input int n);
    repeat (n) begin
      vblank = 1'b1;
      repeat (3) begin step(1'b0, 1'b0); check1("no_cpu_rst", cpu_rst, 1'b0); end
      vblank = 1'b0;
      repeat (3) begin step(1'b0, 1'b0); check1("no_cpu_rst", cpu_rst, 1'b0); end
    end
  endtask

  initial begin
    logic [4:0] s;
    int e;
    total = 0; bad = 0; cyc = 0;
    pend_irqres = 1'b1; pend_read = 1'b0; pend_din = 8'hFF;
    drive_idle();
    do_reset();

    // Free-running enable after reset release
    for (int i = 1; i <= 210; i++) begin
      step(1'b0, 1'b0);
      check1("cpu_ce", cpu_ce, (cyc % 68) == 0);
    end

    // Directed read and write
    rom_d = 8'hA5;
    run_cycle(1'b1, 5'b10111, 8'h00, 1'b1, 1'b1, 0);
    run_cycle(1'b0, 5'b01111, 8'h3C, 1'b1, 1'b1, 0);

    // IRQ set, clear, and set-wins-over-clear
    irq_tick = 1'b1;
    step(1'b0, 1'b0);
    run_cycle(1'b0, 5'h1F, 8'h00, 1'b0, 1'b1, 0);
    irq_tick = 1'b1;
    step(1'b0, 1'b0);
    run_cycle(1'b1, 5'h1F, 8'h00, 1'b0, 1'b1, SETUP + 1);

    // Randomized transactions
    for (int t = 0; t < 16; t++) begin
      for (int b = 0; b < 5; b++) s[b] = ($urandom_range(3) != 0);
      ram_d = 8'($urandom); rom_d = 8'($urandom); gfx_d = 8'($urandom);
      pokey_d = 8'($urandom); in_d = 8'($urandom);
      run_cycle(1'($urandom), s, 8'($urandom), 1'b1, 1'b1, 0);
    end

    // Reset in the middle of a write cycle
    cpu_we_l = 1'b0; drive_sel(5'b01111); cpu_dout = 8'h5A;
    wait_ce();
    step(1'b0, 1'b0);
    do_reset();
    drive_idle();

    // Multi-select read is sticky
    ram_d = 8'h11; gfx_d = 8'h22;
    run_cycle(1'b1, 5'b01011, 8'h00, 1'b1, 1'b1, 0);
    check8("conflict_din", cpu_din, 8'h11);
    repeat (10) step(1'b0, 1'b0);
    check1("conflict_sticky", bus_conflict, 1'b1);

    // Watchdog expiry: 8th edge placed so the reset covers a write cycle
    do_reset();
    vblank_edges(7);
    wait_ce();
    e = cyc;
    for (int k = 1; k <= 58; k++) step(1'b0, 1'b0);
    cpu_we_l = 1'b0; drive_sel(5'b01111); cpu_dout = 8'h77;
    vblank = 1'b1;
    for (int k = 59; k <= 99; k++) begin
      if (k == 62) vblank = 1'b0;
      step(1'b0, 1'b0);
      check1("wdog_cpu_rst", cpu_rst, (cyc - e >= 60) && (cyc - e <= 75));
      check1("wdog_cpu_ce", cpu_ce, (cyc - e) == 68);
    end
    drive_idle();

    // Watchdog write after 7 edges prevents the reset
    do_reset();
    vblank_edges(7);
    run_cycle(1'b0, 5'h1F, 8'h00, 1'b1, 1'b0, 0);
    vblank_edges(7);
    repeat (5) begin step(1'b0, 1'b0); check1("no_cpu_rst", cpu_rst, 1'b0); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
